// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction-fetch sequencer driving an edge-sensitive PC increment
//
// Fetches one word per instruction at the current PC and hands it to decode over a
// valid/ready handshake, then pulses pc_incr once so the PC advances by one.
// Runs from start until halt, LAST_ADDR, or a memory timeout.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   start        begin fetching (sampled in IDLE only)
//   halt         stop at the next instruction boundary (sampled on acceptance)
//   pc           current program counter value
//   pc_incr      PC increment strobe; PC advances on its 0->1 edge
//   mem_req      memory read request
//   mem_addr     registered read address
//   mem_ack      read data valid
//   mem_data     read data
//   instr_valid  instr holds a fetched word
//   instr        registered fetched word
//   instr_ready  decode stage accepts instr
//   busy         sequencer not idle
//   done         one-cycle pulse on normal completion
//   err          sticky timeout flag
module fetch_seq #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int LAST_ADDR = 2**ADDR_W-1,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_incr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  input  logic              instr_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_STEP,
    S_GAP,
    S_ERR
  } state_t;

  localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(LAST_ADDR);

  state_t              state_q, state_d;
  logic [7:0]          timer_q, timer_d;
  logic                pc_incr_q, pc_incr_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      pc_incr_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pc_incr_q     <= pc_incr_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    pc_incr_d     = 1'b0;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    done_d        = 1'b0;
    err_d         = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mem_addr_d = pc;
          mem_req_d  = 1'b1;
          err_d      = 1'b0;
          timer_d    = '0;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (mem_ack) begin
          instr_d       = mem_data;
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = S_HOLD;
        end else if (timer_q == TMO_LAST) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_ERR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      S_HOLD: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          if (halt || (pc == LAST_PC)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Registered strobe: high exactly while in STEP.
            pc_incr_d = 1'b1;
            state_d   = S_STEP;
          end
        end
      end

      S_STEP: begin
        state_d = S_GAP;
      end

      S_GAP: begin
        // pc has been stepped by now, so latch the new address.
        mem_addr_d = pc;
        mem_req_d  = 1'b1;
        timer_d    = '0;
        state_d    = S_REQ;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc_incr     = pc_incr_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - self-checking bench for fetch_seq
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [7:0]  pc = 8'd0;
  logic        pc_incr;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  logic        pc_load = 1'b1;
  logic [7:0]  pc_load_val = 8'd0;
  logic        incr_d1 = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  int pulse_cnt = 0;
  int low_run = 0;
  int viol = 0;
  logic mon_prev = 1'b0;

  fetch_seq #(
    .ADDR_W(8),
    .DATA_W(16),
    .LAST_ADDR(3),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .halt(halt),
    .pc(pc),
    .pc_incr(pc_incr),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_data(mem_data),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_ready(instr_ready),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // Memory: word = {A5, addr} while acking, junk otherwise.
  assign mem_data = mem_ack ? {8'hA5, mem_addr} : 16'hDEAD;

  // Program counter with edge-sensitive increment.
  always @(posedge clk) begin
    incr_d1 <= pc_incr;
    if (pc_load) pc <= pc_load_val;
    else if (pc_incr && !incr_d1) pc <= pc + 8'd1;
  end

  // pc_incr shape monitor: 1-cycle pulses, >=2 low cycles between.
  always @(negedge clk) begin
    mon_prev <= pc_incr;
    if (pc_incr) begin
      low_run <= 0;
      if (!mon_prev) begin
        pulse_cnt <= pulse_cnt + 1;
        if (pulse_cnt > 0 && low_run < 2) viol <= viol + 1;
      end else begin
        viol <= viol + 1;
      end
    end else begin
      low_run <= low_run + 1;
    end
  end

  typedef struct {
    logic        start, ack, ready, halt;
    logic        pc_incr, mem_req;
    logic [7:0]  mem_addr;
    logic        instr_valid;
    logic [15:0] instr;
    logic        busy, done, err;
  } vec_t;

  vec_t vt[16];
  vec_t zv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string p, input vec_t v);
    chk({p, ".pc_incr"}, 32'(pc_incr), 32'(v.pc_incr));
    chk({p, ".mem_req"}, 32'(mem_req), 32'(v.mem_req));
    chk({p, ".mem_addr"}, 32'(mem_addr), 32'(v.mem_addr));
    chk({p, ".instr_valid"}, 32'(instr_valid), 32'(v.instr_valid));
    chk({p, ".instr"}, 32'(instr), 32'(v.instr));
    chk({p, ".busy"}, 32'(busy), 32'(v.busy));
    chk({p, ".done"}, 32'(done), 32'(v.done));
    chk({p, ".err"}, 32'(err), 32'(v.err));
  endtask

  task automatic set_pc(input logic [7:0] v);
    pc_load_val = v;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    zv = '{default: '0};
    //        st  ack rdy hlt  incr req addr   vld instr     busy done err
    vt[0]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,8'd0,1'b0,16'h0000,1'b1,1'b0,1'b0};
    vt[1]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,8'd0,1'b1,16'hA500,1'b1,1'b0,1'b0};
    vt[2]  = '{1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,8'd0,1'b0,16'hA500,1'b1,1'b0,1'b0};
    vt[3]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,8'd0,1'b0,16'hA500,1'b1,1'b0,1'b0};
    vt[4]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,8'd1,1'b0,16'hA500,1'b1,1'b0,1'b0};
    vt[5]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,8'd1,1'b1,16'hA501,1'b1,1'b0,1'b0};
    vt[6]  = '{1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,8'd1,1'b0,16'hA501,1'b1,1'b0,1'b0};
    vt[7]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,8'd1,1'b0,16'hA501,1'b1,1'b0,1'b0};
    vt[8]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,8'd2,1'b0,16'hA501,1'b1,1'b0,1'b0};
    vt[9]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,8'd2,1'b1,16'hA502,1'b1,1'b0,1'b0};
    vt[10] = '{1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,8'd2,1'b0,16'hA502,1'b1,1'b0,1'b0};
    vt[11] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,8'd2,1'b0,16'hA502,1'b1,1'b0,1'b0};
    vt[12] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,8'd3,1'b0,16'hA502,1'b1,1'b0,1'b0};
    vt[13] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,8'd3,1'b1,16'hA503,1'b1,1'b0,1'b0};
    vt[14] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,8'd3,1'b0,16'hA503,1'b0,1'b1,1'b0};
    vt[15] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,8'd3,1'b0,16'hA503,1'b0,1'b0,1'b0};

    // Reset state
    tick();
    tick();
    chk_vec("reset", zv);
    reset = 1'b1;
    pc_load = 1'b0;

    // Basic run, same-cycle ack, ready tied high
    base = pulse_cnt;
    for (int i = 0; i < 16; i++) begin
      start = vt[i].start;
      mem_ack = vt[i].ack;
      instr_ready = vt[i].ready;
      halt = vt[i].halt;
      tick();
      chk_vec($sformatf("v%0d", i), vt[i]);
    end
    start = 1'b0;
    chk("incr_pulses", 32'(pulse_cnt - base), 32'd3);
    chk("pc_end", 32'(pc), 32'd3);

    // Delayed ack and stalled decode
    set_pc(8'd0);
    start = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0;
    tick();
    start = 1'b0;
    chk("st_req", 32'(mem_req), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_req_hold", 32'(mem_req), 32'd1);
      chk("st_addr_hold", 32'(mem_addr), 32'd0);
      chk("st_no_incr_a", 32'(pc_incr), 32'd0);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("st_valid", 32'(instr_valid), 32'd1);
    chk("st_instr", 32'(instr), 32'hA500);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("st_valid_hold", 32'(instr_valid), 32'd1);
      chk("st_instr_hold", 32'(instr), 32'hA500);
      chk("st_no_incr_r", 32'(pc_incr), 32'd0);
    end
    instr_ready = 1'b1; mem_ack = 1'b1;
    tick();
    chk("st_accept", 32'(instr_valid), 32'd0);
    chk("st_step", 32'(pc_incr), 32'd1);
    tick();
    chk("st_gap_pc", 32'(pc), 32'd1);
    tick(); tick(); tick(); tick();
    tick();
    chk("h_addr2", 32'(mem_addr), 32'd2);
    tick();
    chk("h_instr2", 32'(instr), 32'hA502);

    // Halt on acceptance at pc=2
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("h_done", 32'(done), 32'd1);
    chk("h_busy", 32'(busy), 32'd0);
    chk("h_no_incr", 32'(pc_incr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("h_idle_req", 32'(mem_req), 32'd0);
      chk("h_pc_kept", 32'(pc), 32'd2);
      chk("h_done_pulse", 32'(done), 32'd0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r_req", 32'(mem_req), 32'd1);
    chk("r_addr", 32'(mem_addr), 32'd2);
    tick();
    // start while busy is ignored
    start = 1'b1;
    tick();
    chk("b_step", 32'(pc_incr), 32'd1);
    chk("b_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("b_addr3", 32'(mem_addr), 32'd3);
    start = 1'b0;
    tick();
    tick();
    chk("b_done", 32'(done), 32'd1);
    chk("b_idle", 32'(busy), 32'd0);
    // back-to-back restart from current pc
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bb_req", 32'(mem_req), 32'd1);
    chk("bb_addr", 32'(mem_addr), 32'd3);
    chk("bb_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("bb_done", 32'(done), 32'd1);

    // Timeout
    set_pc(8'd0);
    start = 1'b1; mem_ack = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("to_noerr%0d", k), 32'(err), 32'd0);
      chk($sformatf("to_req%0d", k), 32'(mem_req), 32'd1);
    end
    tick();
    chk("to_err", 32'(err), 32'd1);
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_busy", 32'(busy), 32'd1);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("err_stay", 32'(err), 32'd1);
      chk("err_busy", 32'(busy), 32'd1);
      chk("err_req", 32'(mem_req), 32'd0);
    end
    start = 1'b0;
    #3 reset = 1'b0;
    #1 chk("err_rst_err", 32'(err), 32'd0);
    chk("err_rst_busy", 32'(busy), 32'd0);
    #2 reset = 1'b1;
    tick();

    // Ack in the timeout cycle wins
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("ack15_err", 32'(err), 32'd0);
    chk("ack15_valid", 32'(instr_valid), 32'd1);
    chk("ack15_instr", 32'(instr), 32'hA500);

    // Async reset in STEP
    tick();
    chk("rs_step", 32'(pc_incr), 32'd1);
    #3 reset = 1'b0;
    #1 chk_vec("rst_step", zv);
    #2 reset = 1'b1;
    tick();
    chk("rs_idle", 32'(busy), 32'd0);
    chk("rs_incr", 32'(pc_incr), 32'd0);

    // Async reset in REQ
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rq_req", 32'(mem_req), 32'd1);
    #3 reset = 1'b0;
    #1 chk_vec("rst_req", zv);
    #2 reset = 1'b1;
    tick();
    chk("rq_idle", 32'(busy), 32'd0);
    chk("rq_noreq", 32'(mem_req), 32'd0);

    tick();
    chk("incr_shape", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
